rtc_bus_engine: RTL and testbench

- Parametrised transaction engine for multiplexed address/data RTC buses (V3023-class): active-low AD, CS, RD, WR strobes, one shared tri-state bus.
- Each phase duration is a parameter in clk cycles. Adds burst access (N beats, auto-incrementing address), read-data capture, write-data pop handshake, and an explicit request/ack/done interface.
- Sits between the register-map / command sequencer and the top-level pads; the top level owns the tri-state buffer.

---
 rtl/rtc_bus_pkg.sv | 25 ++
 rtl/rtc_phase_timer.sv | 25 ++
 rtl/rtc_bus_engine.sv | 177 +++++++++++++++++
 tb/tb_rtc_bus_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared state encoding and default phase timings for the RTC bus engine.
package rtc_bus_pkg;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        IDLE = 4'd0,
        ASET = 4'd1,
        ASTB = 4'd2,
        AHLD = 4'd3,
        REC1 = 4'd4,
        DRD  = 4'd5,
        DWR  = 4'd6,
        DHLD = 4'd7,
        REC2 = 4'd8
    } state_t;

    localparam int T_ADS_DEF = 2;
    localparam int T_CS_DEF  = 6;
    localparam int T_AH_DEF  = 2;
    localparam int T_REC_DEF = 10;
    localparam int T_RD_DEF  = 8;
    localparam int T_WR_DEF  = 8;
    localparam int T_DH_DEF  = 2;
    localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module rtc_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_expired
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt     = r_cnt;
    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/rtc_bus_engine.sv
// Multiplexed address/data RTC bus transaction engine with burst support.
// Outputs are decoded from the next state so every strobe is registered.
module rtc_bus_engine
    import rtc_bus_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16,
    parameter int T_ADS     = T_ADS_DEF,
    parameter int T_CS      = T_CS_DEF,
    parameter int T_AH      = T_AH_DEF,
    parameter int T_REC     = T_REC_DEF,
    parameter int T_RD      = T_RD_DEF,
    parameter int T_WR      = T_WR_DEF,
    parameter int T_DH      = T_DH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    localparam int LW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic          i_rw,
    input  logic [DW-1:0] i_addr,
    input  logic [LW-1:0] i_len,
    output logic          o_ack,
    input  logic [DW-1:0] i_wdata,
    output logic          o_wdata_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_rdata_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_ad_n,
    output logic          o_cs_n,
    output logic          o_rd_n,
    output logic          o_wr_n,
    output logic [DW-1:0] o_bus_out,
    output logic          o_bus_oe,
    input  logic [DW-1:0] i_bus_in
);
    state_t          r_state;
    state_t          w_nxt_state;
    logic            r_rw;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   w_nxt_addr;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_beat;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_load_val;
    logic            w_expired;
    logic            w_load;
    logic            w_last_nxt;
    logic            w_start;
    logic            w_last_beat;
    logic            w_rd_capture;

    assign w_start      = (r_state == IDLE) && i_req;
    assign w_last_beat  = (r_beat == r_len);
    assign w_rd_capture = (r_state == DRD) && w_expired;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_addr;
        case (r_state)
            IDLE: if (i_req) begin
                w_nxt_state = ASET;
                w_nxt_addr  = i_addr;
            end
            ASET: if (w_expired) w_nxt_state = ASTB;
            ASTB: if (w_expired) w_nxt_state = AHLD;
            AHLD: if (w_expired) w_nxt_state = REC1;
            REC1: if (w_expired) w_nxt_state = r_rw ? DRD : DWR;
            DRD:  if (w_expired) w_nxt_state = REC2;
            DWR:  if (w_expired) w_nxt_state = DHLD;
            DHLD: if (w_expired) w_nxt_state = REC2;
            REC2: if (w_expired) begin
                if (w_last_beat) begin
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_state = ASET;
                    w_nxt_addr  = r_addr + 1'b1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_comb begin
        w_load_val = '0;
        case (w_nxt_state)
            ASET:       w_load_val = CNT_W'(T_ADS - 1);
            ASTB:       w_load_val = CNT_W'(T_CS - 1);
            AHLD:       w_load_val = CNT_W'(T_AH - 1);
            REC1, REC2: w_load_val = CNT_W'(T_REC - 1);
            DRD:        w_load_val = CNT_W'(T_RD - 1);
            DWR:        w_load_val = CNT_W'(T_WR - 1);
            DHLD:       w_load_val = CNT_W'(T_DH - 1);
            default:    w_load_val = '0;
        endcase
    end

    assign w_load = (w_nxt_state != r_state);
    // True when the coming cycle is the final cycle of its phase.
    assign w_last_nxt = w_load ? (w_load_val == '0) : (w_cnt == CNT_W'(1));

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_cnt      (w_cnt),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            o_ack         <= 1'b0;
            o_wdata_pop   <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_ad_n        <= 1'b1;
            o_cs_n        <= 1'b1;
            o_rd_n        <= 1'b1;
            o_wr_n        <= 1'b1;
            o_bus_out     <= '0;
            o_bus_oe      <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_addr        <= w_nxt_addr;
            o_ack         <= w_start;
            o_busy        <= (w_nxt_state != IDLE);
            o_done        <= (r_state == REC2) && w_expired && w_last_beat;
            o_wdata_pop   <= (w_nxt_state == REC1) && w_last_nxt && !r_rw;
            o_rdata_valid <= w_rd_capture;
            if (w_rd_capture)
                o_rdata <= i_bus_in;

            if (w_start) begin
                r_rw   <= i_rw;
                r_len  <= i_len;
                r_beat <= '0;
            end else if ((r_state == REC2) && w_expired && !w_last_beat) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_nxt_state == ASET)
                o_bus_out <= w_nxt_addr;
            else if (o_wdata_pop)
                o_bus_out <= i_wdata;

            o_ad_n   <= 1'b1;
            o_cs_n   <= 1'b1;
            o_rd_n   <= 1'b1;
            o_wr_n   <= 1'b1;
            o_bus_oe <= 1'b0;
            case (w_nxt_state)
                ASET: begin o_ad_n <= 1'b0; o_bus_oe <= 1'b1; end
                ASTB: begin
                    o_ad_n   <= 1'b0;
                    o_cs_n   <= 1'b0;
                    o_wr_n   <= 1'b0;
                    o_bus_oe <= 1'b1;
                end
                AHLD: begin o_ad_n <= 1'b0; o_bus_oe <= 1'b1; end
                DRD:  begin o_cs_n <= 1'b0; o_rd_n <= 1'b0; end
                DWR:  begin o_cs_n <= 1'b0; o_wr_n <= 1'b0; o_bus_oe <= 1'b1; end
                DHLD: o_bus_oe <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_bus_engine.sv
// Bench for rtc_bus_engine: default-timing and all-ones-timing instances
// compared cycle by cycle against a phase-table model of each transaction.
`timescale 1ns/1ps
module tb_rtc_bus_engine;
    typedef enum int {P_ASET, P_ASTB, P_AHLD, P_REC1, P_DRD, P_DWR, P_DHLD, P_REC2} phase_e;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       req, rw;
    logic [7:0] addr, wdata, bus_in;
    logic [3:0] len;
    logic [1:0] ack, pop, rv, busy, done, ad_n, cs_n, rd_n, wr_n, oe;
    logic [7:0] rdata [2];
    logic [7:0] bus_out [2];

    int ta [2]  = '{2, 1};
    int tc [2]  = '{6, 1};
    int th [2]  = '{2, 1};
    int tr [2]  = '{10, 1};
    int trd [2] = '{8, 1};
    int twr [2] = '{8, 1};
    int tdh [2] = '{2, 1};

    int n_checks = 0;
    int n_fail   = 0;

    logic       cur_rw;
    logic [7:0] cur_addr;
    logic [3:0] cur_len;
    logic [7:0] rd_vals [16];
    logic [7:0] wr_vals [16];
    int         pops, rd_idx;
    logic       pop_pend, prev_rd_n;
    int         force_rd = -1;
    int         force_wr = -1;

    always #5 clk = ~clk;

    rtc_bus_engine u_dut0 (
        .clk(clk), .reset(reset), .i_req(req & ~sel), .i_rw(rw), .i_addr(addr), .i_len(len),
        .o_ack(ack[0]), .i_wdata(wdata), .o_wdata_pop(pop[0]), .o_rdata(rdata[0]),
        .o_rdata_valid(rv[0]), .o_busy(busy[0]), .o_done(done[0]), .o_ad_n(ad_n[0]),
        .o_cs_n(cs_n[0]), .o_rd_n(rd_n[0]), .o_wr_n(wr_n[0]), .o_bus_out(bus_out[0]),
        .o_bus_oe(oe[0]), .i_bus_in(bus_in)
    );

    rtc_bus_engine #(.T_ADS(1), .T_CS(1), .T_AH(1), .T_REC(1), .T_RD(1), .T_WR(1), .T_DH(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_req(req & sel), .i_rw(rw), .i_addr(addr), .i_len(len),
        .o_ack(ack[1]), .i_wdata(wdata), .o_wdata_pop(pop[1]), .o_rdata(rdata[1]),
        .o_rdata_valid(rv[1]), .o_busy(busy[1]), .o_done(done[1]), .o_ad_n(ad_n[1]),
        .o_cs_n(cs_n[1]), .o_rd_n(rd_n[1]), .o_wr_n(wr_n[1]), .o_bus_out(bus_out[1]),
        .o_bus_oe(oe[1]), .i_bus_in(bus_in)
    );

    function automatic int beat_len(input logic r, input int s);
        if (r) return ta[s] + tc[s] + th[s] + 2 * tr[s] + trd[s];
        return ta[s] + tc[s] + th[s] + 2 * tr[s] + twr[s] + tdh[s];
    endfunction

    function automatic logic [9:0] obs_vec(input int s);
        return {ad_n[s], cs_n[s], rd_n[s], wr_n[s], oe[s], busy[s], ack[s], done[s], pop[s], rv[s]};
    endfunction

    // Expected outputs at cycle t (cycle 1 is the one after the accepting edge).
    task automatic check_cycle(input int t);
        phase_e     ph [7];
        int         dur [7];
        int         s, np, tbeat, nb, b, o, p, q, acc;
        logic       e_ad, e_cs, e_rd, e_wr, e_oe, e_busy, e_ack, e_done, e_pop, e_rv;
        logic [7:0] exp_bus;
        logic [9:0] exp_v, got_v;
        s = sel ? 1 : 0;
        if (cur_rw) begin
            np  = 6;
            ph  = '{P_ASET, P_ASTB, P_AHLD, P_REC1, P_DRD, P_REC2, P_REC2};
            dur = '{ta[s], tc[s], th[s], tr[s], trd[s], tr[s], 0};
        end else begin
            np  = 7;
            ph  = '{P_ASET, P_ASTB, P_AHLD, P_REC1, P_DWR, P_DHLD, P_REC2};
            dur = '{ta[s], tc[s], th[s], tr[s], twr[s], tdh[s], tr[s]};
        end
        tbeat = beat_len(cur_rw, s);
        nb    = int'(cur_len) + 1;
        {e_ad, e_cs, e_rd, e_wr} = 4'b1111;
        e_oe = 0; e_pop = 0; e_rv = 0; exp_bus = 8'h00; b = 0;
        e_busy = (t >= 1) && (t <= nb * tbeat);
        e_ack  = (t == 1);
        e_done = (t == nb * tbeat + 1);
        if (e_busy) begin
            b = (t - 1) / tbeat;
            o = (t - 1) % tbeat;
            acc = 0; p = 0;
            while (p < np - 1 && o >= acc + dur[p]) begin
                acc += dur[p];
                p++;
            end
            q = o - acc;
            case (ph[p])
                P_ASET: begin e_ad = 0; e_oe = 1; exp_bus = 8'(cur_addr + b); end
                P_ASTB: begin e_ad = 0; e_cs = 0; e_wr = 0; e_oe = 1; exp_bus = 8'(cur_addr + b); end
                P_AHLD: begin e_ad = 0; e_oe = 1; exp_bus = 8'(cur_addr + b); end
                P_DRD:  begin e_cs = 0; e_rd = 0; end
                P_DWR:  begin e_cs = 0; e_wr = 0; e_oe = 1; exp_bus = wr_vals[b]; end
                P_DHLD: begin e_oe = 1; exp_bus = wr_vals[b]; end
                default: ;
            endcase
            e_pop = (ph[p] == P_REC1) && (q == dur[p] - 1) && !cur_rw;
            e_rv  = cur_rw && (ph[p] == P_REC2) && (q == 0);
        end
        exp_v = {e_ad, e_cs, e_rd, e_wr, e_oe, e_busy, e_ack, e_done, e_pop, e_rv};
        got_v = obs_vec(s);
        n_checks++;
        assert (got_v === exp_v) else begin
            n_fail++;
            $error("FAIL ctl t=%0d dut=%0d ad,cs,rd,wr,oe,busy,ack,done,pop,rv observed=%b expected=%b", t, s, got_v, exp_v);
        end
        n_checks++;
        assert (!(rd_n[s] === 1'b0 && (wr_n[s] === 1'b0 || oe[s] === 1'b1))) else begin
            n_fail++;
            $error("FAIL strobe_inv t=%0d dut=%0d observed rd_n=%b wr_n=%b oe=%b expected rd_n low only with wr_n=1 oe=0", t, s, rd_n[s], wr_n[s], oe[s]);
        end
        if (e_oe) begin
            n_checks++;
            assert (bus_out[s] === exp_bus) else begin
                n_fail++;
                $error("FAIL bus_out t=%0d dut=%0d observed=%h expected=%h", t, s, bus_out[s], exp_bus);
            end
        end
        if (e_rv) begin
            n_checks++;
            assert (rdata[s] === rd_vals[b]) else begin
                n_fail++;
                $error("FAIL rdata t=%0d dut=%0d beat=%0d observed=%h expected=%h", t, s, b, rdata[s], rd_vals[b]);
            end
        end
    endtask

    // Requester data source and RTC-side read data, both reacting to the DUT.
    task automatic drive_models();
        if (pop_pend) pops++;
        pop_pend = pop[sel];
        wdata    = wr_vals[pops % 16];
        if (prev_rd_n == 1'b0 && rd_n[sel] == 1'b1) rd_idx++;
        prev_rd_n = rd_n[sel];
        bus_in = (rd_n[sel] == 1'b0) ? rd_vals[rd_idx % 16] : 8'($urandom);
    endtask

    task automatic start_txn(input logic r, input logic [7:0] a, input logic [3:0] l);
        cur_rw = r; cur_addr = a; cur_len = l;
        for (int i = 0; i < 16; i++) begin
            rd_vals[i] = 8'($urandom);
            wr_vals[i] = 8'($urandom);
        end
        if (force_rd >= 0) rd_vals[0] = 8'(force_rd);
        if (force_wr >= 0) wr_vals[0] = 8'(force_wr);
        pops = 0; pop_pend = 0; rd_idx = 0; prev_rd_n = 1'b1;
        req = 1; rw = r; addr = a; len = l; wdata = wr_vals[0];
    endtask

    task automatic run_txn(input logic r, input logic [7:0] a, input logic [3:0] l,
                           input bit prearm, input logic nr, input logic [7:0] na, input logic [3:0] nl);
        int tend;
        start_txn(r, a, l);
        tend = (int'(l) + 1) * beat_len(r, sel ? 1 : 0) + 1;
        for (int t = 1; t <= tend; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(t);
            if (t == 1) req = 0;
            if (prearm && t == 10) begin req = 1; rw = nr; addr = na; len = nl; end
            drive_models();
        end
    endtask

    task automatic check_quiet(input string tag, input int s);
        n_checks++;
        assert (obs_vec(s) === 10'b11110_00000) else begin
            n_fail++;
            $error("FAIL %s dut=%0d ad,cs,rd,wr,oe,busy,ack,done,pop,rv observed=%b expected=%b", tag, s, obs_vec(s), 10'b11110_00000);
        end
    endtask

    initial begin
        reset = 1; sel = 0; req = 0; rw = 0; addr = 0; len = 0; wdata = 0; bus_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_quiet("reset_ctl", k);
            n_checks++;
            assert (bus_out[k] === 8'h00 && rdata[k] === 8'h00) else begin
                n_fail++;
                $error("FAIL reset_data dut=%0d observed bus_out=%h rdata=%h expected 00/00", k, bus_out[k], rdata[k]);
            end
        end
        reset = 0;
        @(negedge clk);

        force_rd = 'h5C; run_txn(1'b1, 8'h0A, 4'd0, 0, 0, 0, 0); force_rd = -1;
        force_wr = 'h37; run_txn(1'b0, 8'h02, 4'd0, 0, 0, 0, 0); force_wr = -1;
        run_txn(1'b1, 8'hFE, 4'd2, 0, 0, 0, 0);
        run_txn(1'b0, 8'hFF, 4'd1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 3)), 0, 0, 0, 0);

        // Abort a write burst with reset after 15 cycles.
        start_txn(1'b0, 8'h33, 4'd1);
        for (int t = 1; t <= 15; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(t);
            if (t == 1) req = 0;
            drive_models();
        end
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midreset", 0);
        reset = 0;
        for (int t = 0; t < 45; t++) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("after_reset", 0);
        end
        run_txn(1'b1, 8'h21, 4'd0, 0, 0, 0, 0);

        // req raised mid-transaction and held through done.
        run_txn(1'b0, 8'h40, 4'd1, 1, 1'b1, 8'h80, 4'd0);
        run_txn(1'b1, 8'h80, 4'd0, 0, 0, 0, 0);

        sel = 1;
        @(negedge clk);
        run_txn(1'b1, 8'hFD, 4'd3, 0, 0, 0, 0);
        run_txn(1'b0, 8'h10, 4'd2, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("final_idle", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
